div_share_sched: RTL and testbench
==================================

Name: div_share_sched

Overview:
- Time-multiplexes one shared 2-cycle-hold divider (15-bit signed operands in, IEEE754 single out) between NREQ requesters in the subpixel-edge datapath.
- Round-robin arbitration; one new division is issued every 2 cycles.
- Each issue carries an in-flight tag through a shift pipeline matched to divider latency, so every result returns to its requester with its ID and a divide-by-zero flag.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- DIV_LAT, 7, clock edges from the operand-capture edge to the edge at which div_result/div_divbyzero are valid for that issue.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request; held with operands until granted
- req_a  in  NREQ*15  packed signed dividends; requester i uses bits [15i+14:15i]
- req_b  in  NREQ*15  packed signed divisors, same packing
- gnt  out  NREQ  one-hot combinational grant; operands captured on the edge where gnt[i]=1
- div_a  out  15  registered dividend to divider
- div_b  out  15  registered divisor to divider
- div_result  in  32  divider float result
- div_divbyzero  in  1  divider zero flag
- rsp_valid  out  1  one-cycle pulse, response valid
- rsp_id  out  IDW  requester ID of response
- rsp_data  out  32  float result
- rsp_dz  out  1  divide-by-zero (divisor was 0 or divider flagged)
- busy  out  1  any issue in flight or in HOLD

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, div_a=0, div_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_dz=0, busy=0.
  - All tag stages invalid; FSM=SLOT; rr_ptr=NREQ-1, so requester 0 has first priority.
- FSM has two states, SLOT and HOLD.
  - SLOT: if any req, winner = first set bit searching upward from rr_ptr+1 modulo NREQ.
    - gnt[winner]=1 combinationally; all other gnt bits 0.
    - On the edge: div_a/div_b <= winner operands; rr_ptr <= winner; push tag {valid=1, id=winner, bz=(req_b==0)}; go to HOLD.
  - SLOT with no req: gnt=0; div_a/div_b hold their previous value; push invalid tag; stay in SLOT.
  - HOLD: gnt=0; div_a/div_b unchanged (the second hold cycle); push invalid tag; go to SLOT.
- Throughput and fairness:
  - Maximum throughput is 1 issue per 2 cycles.
  - Under continuous all-ones req, grant order is 0,1,2,3,0,... with one grant every 2 cycles.
- Tag pipeline:
  - DIV_LAT stages of {valid, id, bz}; shifts every cycle.
  - A tag pushed at edge E0 reaches the last stage after edge E0+DIV_LAT-1.
  - At edge E0+DIV_LAT: rsp_valid <= tag.valid; rsp_id <= tag.id; rsp_data <= div_result; rsp_dz <= tag.bz | div_divbyzero.
  - The response is therefore visible in the cycle after edge E0+DIV_LAT.
  - rsp_valid=0 cycles keep the previous rsp_id/rsp_data/rsp_dz.
- Divide by zero: the divider is still issued with b=0; its result is passed through unaltered, and rsp_dz=1.
- busy = (FSM==HOLD) | OR of all stage valid bits.
- No backpressure on rsp: consumers must accept a response in the cycle it is presented.
- A requester deasserting req before being granted drops its request; no state is kept for it.
- Reset mid-operation discards every in-flight tag; no rsp_valid pulse follows reset for issues made before reset.
- Width rules:
  - Operands pass through bit-exact (no sign manipulation).
  - The ID fits IDW; ID values >= NREQ never occur.

Test Plan:
- After reset, req=4'b0001, a0=300, b0=-4 -> gnt[0] high 1 cycle; div_a=300, div_b=-4 held exactly 2 cycles; one rsp_valid pulse after DIV_LAT edges with rsp_id=0, rsp_data=32'hC2960000 (-75.0), rsp_dz=0.
- req=4'b1111 held for 16 cycles with distinct operands -> grants 0,1,2,3,0,1,2,3 every 2nd cycle; responses arrive in the same order, 2 cycles apart, each matching its operands.
- req=4'b1010 with rr_ptr=1 (requester 1 granted last) -> next grant is 3, then 1; never 0 or 2.
- Requester 2 with b=0, a=17 -> rsp_id=2, rsp_dz=1, rsp_data equal to the divider output at that edge.
- Assert rst_n=0 for 1 cycle while 3 issues are in flight -> all outputs 0 immediately; no rsp_valid afterwards until new grants; first grant after reset goes to the lowest-index requester.
- Single isolated request, then idle -> busy high from the grant edge until the rsp_valid edge, then 0; div_a/div_b retain the last operands while idle.

Source files
------------

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one 2-cycle-hold divider among NREQ requesters.
// Each issue carries a {valid,id,bz} tag down a pipeline matched to divider latency.
module div_share_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int DIV_LAT = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*15-1:0]   req_a,
    input  logic [NREQ*15-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic [14:0]          div_a,
    output logic [14:0]          div_b,
    input  logic [31:0]          div_result,
    input  logic                 div_divbyzero,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_dz,
    output logic                 busy
);

    typedef enum logic {SLOT, HOLD} state_t;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           bz;
    } tag_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    tag_t           tags [DIV_LAT];

    logic           found;
    logic [IDW-1:0] win;
    logic [IDW-1:0] cand;
    logic [14:0]    win_a;
    logic [14:0]    win_b;
    logic           issue;
    tag_t           push;

    // Search upward from the slot after the last winner, wrapping at NREQ.
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win) begin
                win_a = req_a[i*15 +: 15];
                win_b = req_b[i*15 +: 15];
            end
        end
    end

    // Grant is forced low while reset is held so no requester sees a phantom capture.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        gnt       = '0;
        push      = '0;
        case (state)
            SLOT: begin
                if (found) begin
                    issue     = 1'b1;
                    gnt[win]  = rst_n;
                    push      = '{valid: 1'b1, id: win, bz: (win_b == '0)};
                    state_nxt = HOLD;
                end
            end
            HOLD: state_nxt = SLOT;
        endcase
    end

    always_comb begin
        busy = (state == HOLD);
        for (int i = 0; i < DIV_LAT; i++) begin
            busy = busy | tags[i].valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SLOT;
            rr_ptr    <= IDW'(NREQ - 1);
            div_a     <= '0;
            div_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_dz    <= 1'b0;
            // NOTE: the tag array is reset because reset must discard every in-flight issue.
            for (int i = 0; i < DIV_LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (issue) begin
                div_a  <= win_a;
                div_b  <= win_b;
                rr_ptr <= win;
            end
            tags[0] <= push;
            for (int i = 1; i < DIV_LAT; i++) begin
                tags[i] <= tags[i-1];
            end
            rsp_valid <= tags[DIV_LAT-1].valid;
            if (tags[DIV_LAT-1].valid) begin
                rsp_id   <= tags[DIV_LAT-1].id;
                rsp_data <= div_result;
                rsp_dz   <= tags[DIV_LAT-1].bz | div_divbyzero;
            end
        end
    end

endmodule

// File: tb/tb_div_share_sched.sv
// Directed bench for div_share_sched with a behavioural divider stand-in and a
// response scoreboard filled at grant time and drained on rsp_valid.
module tb_div_share_sched;

    localparam int          NREQ    = 4;
    localparam int          IDW     = 2;
    localparam int          DIV_LAT = 7;
    localparam logic [14:0] MAGIC   = 15'd1000;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*15-1:0]   req_a;
    logic [NREQ*15-1:0]   req_b;
    logic [NREQ-1:0]      gnt;
    logic [14:0]          div_a;
    logic [14:0]          div_b;
    logic [31:0]          div_result;
    logic                 div_divbyzero;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_data;
    logic                 rsp_dz;
    logic                 busy;

    div_share_sched #(.NREQ(NREQ), .IDW(IDW), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .div_a(div_a), .div_b(div_b),
        .div_result(div_result), .div_divbyzero(div_divbyzero),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_dz(rsp_dz), .busy(busy)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    int   gq [$];
    int   gcyc [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rsp_seen = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Integer quotient encoded as IEEE754 single; operands used here divide exactly.
    function automatic logic [31:0] exp_float(input logic signed [14:0] a, input logic signed [14:0] b);
        int q, m, p;
        logic [31:0] r;
        if (b == 0) return 32'h7FC00000;
        q = int'(a) / int'(b);
        if (q == 0) return 32'h0;
        m = (q < 0) ? -q : q;
        p = 0;
        for (int i = 0; i < 31; i++) if ((m >> i) != 0) p = i;
        r[31]    = (q < 0);
        r[30:23] = 8'(127 + p);
        r[22:0]  = 23'(m << (23 - p));
        return r;
    endfunction

    // Divider stand-in: result valid DIV_LAT edges after capture. It raises its own
    // zero flag only for dividend MAGIC, so a zero divisor must be flagged by the tag.
    logic [31:0] sres [DIV_LAT-1];
    logic        sdz  [DIV_LAT-1];
    always @(posedge clk) begin
        sres[0] <= exp_float(div_a, div_b);
        sdz[0]  <= (div_a == MAGIC);
        for (int i = 1; i < DIV_LAT-1; i++) begin
            sres[i] <= sres[i-1];
            sdz[i]  <= sdz[i-1];
        end
    end
    assign div_result    = sres[DIV_LAT-2];
    assign div_divbyzero = sdz[DIV_LAT-2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        int gid;
        logic [14:0] ea, eb;
        exp_t e;
        if (rst_n) begin
            if (gnt != '0) begin
                check("gnt_onehot", 32'($onehot(gnt)), 32'd1);
                gid = 0;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) gid = i;
                ea = req_a[gid*15 +: 15];
                eb = req_b[gid*15 +: 15];
                sb.push_back('{id: gid, data: exp_float(ea, eb),
                               dz: (eb == 0) || (ea == MAGIC), cyc: cyc + 1});
                gq.push_back(gid);
                gcyc.push_back(cyc + 1);
            end
            if (rsp_valid) begin
                rsp_seen++;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
                    check("rsp_latency", 32'(cyc), 32'(e.cyc + DIV_LAT));
                end
            end
        end
    end

    task automatic set_ops(input int id, input logic [14:0] a, input logic [14:0] b);
        req_a[id*15 +: 15] = a;
        req_b[id*15 +: 15] = b;
    endtask

    // Request until granted, then drop req right after the capture edge.
    task automatic issue_one(input int id, input logic [14:0] a, input logic [14:0] b);
        bit ok;
        set_ops(id, a, b);
        req[id] = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("grant_timeout", 32'(gnt), 32'(1 << id));
        @(posedge clk); #1;
        req[id] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic hold_req(input logic [NREQ-1:0] mask, input int n);
        req = mask;
        repeat (n) @(posedge clk);
        #1;
        req = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, seen0;
        bit got;
        rst_n = 1'b0;
        req   = '0;
        req_a = '0;
        req_b = '0;

        // Reset state, with a request pending so a grant leak would show.
        repeat (2) @(posedge clk);
        #1;
        req = 4'b0001;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_div_a", 32'(div_a), 32'd0);
        check("rst_div_b", 32'(div_b), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_dz", 32'(rsp_dz), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req   = '0;

        // Single request 300 / -4; operands held for both divider cycles.
        issue_one(0, 15'sd300, -15'sd4);
        check("t1_div_a_c1", {17'd0, div_a}, {17'd0, 15'sd300});
        check("t1_div_b_c1", {17'd0, div_b}, {17'd0, -15'sd4});
        check("t1_gnt_c1", 32'(gnt), 32'd0);
        @(posedge clk); #1;
        check("t1_div_a_c2", {17'd0, div_a}, {17'd0, 15'sd300});
        check("t1_div_b_c2", {17'd0, div_b}, {17'd0, -15'sd4});
        check("t1_gnt_c2", 32'(gnt), 32'd0);
        check("t1_float", exp_float(15'sd300, -15'sd4), 32'hC2960000);
        wait_idle();

        // Zero divisor on requester 2, then a divider-raised flag on requester 3.
        issue_one(2, 15'sd17, 15'sd0);
        wait_idle();
        issue_one(3, MAGIC, 15'sd8);
        wait_idle();

        // All requesting: strict rotation, one grant every second cycle.
        set_ops(0, 15'sd120, 15'sd2);
        set_ops(1, -15'sd240, 15'sd3);
        set_ops(2, 15'sd360, -15'sd4);
        set_ops(3, -15'sd480, 15'sd5);
        gq.delete();
        gcyc.delete();
        hold_req(4'b1111, 16);
        wait_idle();
        check("t2_grant_count", 32'(gq.size()), 32'd8);
        for (int k = 0; k < gq.size(); k++) begin
            check("t2_grant_order", 32'(gq[k]), 32'(k % NREQ));
            if (k > 0) check("t2_grant_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd2);
        end

        // With requester 1 granted last, 4'b1010 alternates 3,1,3,1.
        issue_one(1, 15'sd99, 15'sd3);
        wait_idle();
        set_ops(3, -15'sd500, -15'sd25);
        gq.delete();
        hold_req(4'b1010, 8);
        wait_idle();
        check("t3_grant_count", 32'(gq.size()), 32'd4);
        for (int k = 0; k < gq.size(); k++) begin
            check("t3_grant_order", 32'(gq[k]), (k % 2 == 0) ? 32'd3 : 32'd1);
        end

        // Isolated request: busy spans exactly the divider latency; operands retained.
        issue_one(0, -15'sd90, 15'sd9);
        check("t6_busy_at_grant", 32'(busy), 32'd1);
        nb  = 0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (busy) nb++;
        end
        check("t6_rsp_seen", 32'(got), 32'd1);
        check("t6_busy_after_rsp", 32'(busy), 32'd0);
        check("t6_busy_cycles", 32'(nb), 32'(DIV_LAT));
        repeat (3) @(posedge clk);
        #1;
        check("t6_div_a_idle", {17'd0, div_a}, {17'd0, -15'sd90});
        check("t6_div_b_idle", {17'd0, div_b}, {17'd0, 15'sd9});
        wait_idle();

        // Reset with three issues in flight: all discarded, lowest requester first after.
        set_ops(0, 15'sd10, 15'sd2);
        set_ops(1, 15'sd21, 15'sd7);
        set_ops(2, -15'sd44, 15'sd11);
        gq.delete();
        req = 4'b0111;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gq.size() >= 3) break;
        end
        check("t5_inflight_grants", 32'(gq.size()), 32'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req   = 4'b0110;
        sb.delete();
        #1;
        check("t5_gnt", 32'(gnt), 32'd0);
        check("t5_div_a", 32'(div_a), 32'd0);
        check("t5_div_b", 32'(div_b), 32'd0);
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_rsp_id", 32'(rsp_id), 32'd0);
        check("t5_rsp_data", rsp_data, 32'd0);
        check("t5_rsp_dz", 32'(rsp_dz), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        seen0 = rsp_seen;
        gq.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gq.size() > 0) break;
        end
        check("t5_first_grant_seen", 32'(gq.size()), 32'd1);
        if (gq.size() > 0) check("t5_first_grant_id", 32'(gq[0]), 32'd1);
        @(posedge clk); #1;
        req = '0;
        wait_idle();
        repeat (DIV_LAT + 2) @(posedge clk);
        #1;
        check("t5_rsp_count", 32'(rsp_seen - seen0), 32'd1);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
